// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode/state types and default width for the sequential ALU
package alu_pkg;

  localparam int W_DEFAULT = 8;

  // Final ALU operation codes, shared with the ALU control decoder
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_SRL  = 3'b010,
    OP_SLL  = 3'b011,
    OP_XOR  = 3'b100,
    OP_XRED = 3'b101,
    OP_AND  = 3'b110,
    OP_PASS = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/alu_seq_comb.sv
// rtl/alu_seq_comb.sv - single-cycle result/carry for all ops; shifts only with ALU_BARREL_SHIFT_EN
module alu_seq_comb
  import alu_pkg::*;
#(
  parameter int W  = W_DEFAULT,
  parameter int SW = $clog2(W)
) (
  input  alu_op_e        op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [W-1:0]   result,
  output logic           carry
);

  logic [W:0] sum;
  logic [W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // Two's-complement subtract so bit W reads as no-borrow
  assign diff = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};

  always_comb begin
    result = a;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[W-1:0];
        carry  = sum[W];
      end
      OP_SUB: begin
        result = diff[W-1:0];
        carry  = diff[W];
      end
`ifdef ALU_BARREL_SHIFT_EN
      OP_SRL:  result = a >> b[SW-1:0];
      OP_SLL:  result = a << b[SW-1:0];
`else
      // Only reached with a zero shift amount; longer shifts go bit-serial
      OP_SRL, OP_SLL: result = a;
`endif
      OP_XOR:  result = a ^ b;
      OP_XRED: result = {{(W-1){1'b0}}, ^a};
      OP_AND:  result = a & b;
      OP_PASS: result = a;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - execute-stage ALU with start/done handshake and bit-serial shifts (ALU_BARREL_SHIFT_EN: single-cycle shifts)
module alu_seq
  import alu_pkg::*;
#(
  parameter int W  = W_DEFAULT,
  parameter int SW = $clog2(W)
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [2:0]   ALUOpFinal,
  input  logic [W-1:0] InA,
  input  logic [W-1:0] InB,
  output logic [W-1:0] Out,
  output logic         Zero,
  output logic         Carry,
  output logic         Done,
  output logic         Ready
);

  state_e       state, state_d;
  alu_op_e      op_in;
  logic         accept;
  logic [W-1:0] comb_res;
  logic         comb_carry;

  assign op_in  = alu_op_e'(ALUOpFinal);
  assign accept = Start & Ready;

`ifndef ALU_BARREL_SHIFT_EN
  logic [SW-1:0] amt;
  logic          long_shift;
  logic [SW-1:0] cnt;
  logic [W-1:0]  work;
  logic [W-1:0]  work_next;
  logic          dir_left;

  assign amt        = InB[SW-1:0];
  assign long_shift = ((op_in == OP_SRL) || (op_in == OP_SLL)) && (amt != '0);
  assign work_next  = dir_left ? {work[W-2:0], 1'b0} : {1'b0, work[W-1:1]};
`endif

  alu_seq_comb #(.W(W), .SW(SW)) u_comb (
    .op     (op_in),
    .a      (InA),
    .b      (InB),
    .result (comb_res),
    .carry  (comb_carry)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    Ready   = (state != ST_SHIFT);
    Done    = (state == ST_DONE);
    case (state)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
`ifdef ALU_BARREL_SHIFT_EN
          state_d = ST_DONE;
`else
          state_d = long_shift ? ST_SHIFT : ST_DONE;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifndef ALU_BARREL_SHIFT_EN
      ST_SHIFT: if (cnt == SW'(1)) state_d = ST_DONE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Out   <= '0;
      Zero  <= 1'b0;
      Carry <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      cnt      <= '0;
      work     <= '0;
      dir_left <= 1'b0;
`endif
    end else begin
`ifdef ALU_BARREL_SHIFT_EN
      if (accept) begin
        Out   <= comb_res;
        Zero  <= (comb_res == '0);
        Carry <= comb_carry;
      end
`else
      if (accept) begin
        if (long_shift) begin
          work     <= InA;
          cnt      <= amt;
          dir_left <= (op_in == OP_SLL);
        end else begin
          Out   <= comb_res;
          Zero  <= (comb_res == '0);
          Carry <= comb_carry;
        end
      end else if (state == ST_SHIFT) begin
        work <= work_next;
        cnt  <= cnt - SW'(1);
        if (cnt == SW'(1)) begin
          Out   <= work_next;
          Zero  <= (work_next == '0);
          Carry <= 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed and randomized checks of alu_seq against an arithmetic reference model
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Start;
  logic [2:0]   ALUOpFinal;
  logic [W-1:0] InA, InB, Out;
  logic         Zero, Carry, Done, Ready;

  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] last_out;

  alu_seq #(.W(W)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .ALUOpFinal (ALUOpFinal),
    .InA        (InA),
    .InB        (InB),
    .Out        (Out),
    .Zero       (Zero),
    .Carry      (Carry),
    .Done       (Done),
    .Ready      (Ready)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result, carry and latency straight from the opcode rules using integer arithmetic
  function automatic void model(input int op, input int a, input int b,
                                output int o, output int c, output int lat);
    int n;
    n   = b % W;
    c   = 0;
    lat = 1;
    case (op)
      0: begin o = (a + b) % (1 << W); c = ((a + b) >= (1 << W)) ? 1 : 0; end
      1: begin o = (a - b + (1 << W)) % (1 << W); c = (a >= b) ? 1 : 0; end
      2: begin o = a >> n; lat = n + 1; end
      3: begin o = (a << n) % (1 << W); lat = n + 1; end
      4: o = a ^ b;
      5: o = $countones(a) % 2;
      6: o = a & b;
      default: o = a;
    endcase
  endfunction

  task automatic do_op(input int op, input int a, input int b, input string tag, input bit pulse);
    int eo, ec, lat;
    model(op, a, b, eo, ec, lat);
    @(negedge Clk);
    check({tag, " idle done"}, Done, 0);
    check({tag, " hold out"}, Out, last_out);
    check({tag, " ready"}, Ready, 1);
    Start      = 1'b1;
    ALUOpFinal = op[2:0];
    InA        = a[W-1:0];
    InB        = b[W-1:0];
    @(posedge Clk);
    #1;
    Start      = 1'b0;
    InA        = W'($urandom);
    InB        = W'($urandom);
    ALUOpFinal = 3'($urandom);
    for (int k = 1; k <= lat; k++) begin
      @(negedge Clk);
      if (k < lat) begin
        check({tag, " busy ready"}, Ready, 0);
        check({tag, " busy done"}, Done, 0);
        if (pulse && lat >= 4 && k == 2) Start = 1'b1;
        if (k == 3) Start = 1'b0;
      end else begin
        check({tag, " done"}, Done, 1);
        check({tag, " out"}, Out, eo);
        check({tag, " zero"}, Zero, (eo == 0) ? 1 : 0);
        check({tag, " carry"}, Carry, ec);
      end
    end
    Start    = 1'b0;
    last_out = eo[W-1:0];
  endtask

  initial begin
    Reset      = 1'b1;
    Start      = 1'b0;
    ALUOpFinal = 3'b000;
    InA        = '0;
    InB        = '0;
    last_out   = '0;
    repeat (2) @(negedge Clk);
    check("reset out", Out, 0);
    check("reset zero", Zero, 0);
    check("reset carry", Carry, 0);
    check("reset done", Done, 0);
    check("reset ready", Ready, 1);
    Reset = 1'b0;

    do_op(0, 8'hF0, 8'h20, "add", 1'b0);
    do_op(1, 8'h3C, 8'h3C, "sub eq", 1'b0);
    do_op(1, 8'h01, 8'h02, "sub borrow", 1'b0);
    do_op(3, 8'h81, 5, "sll5", 1'b1);
    do_op(2, 8'hA5, 0, "srl0", 1'b0);
    do_op(5, 8'h07, 8'h00, "xred", 1'b0);

    // Back-to-back single-cycle ops
    @(negedge Clk);
    Start = 1'b1; ALUOpFinal = 3'b100; InA = 8'hFF; InB = 8'h0F;
    @(posedge Clk);
    #1;
    ALUOpFinal = 3'b110; InA = 8'hF0; InB = 8'h3C;
    @(negedge Clk);
    check("b2b xor done", Done, 1);
    check("b2b xor out", Out, 8'hF0);
    @(posedge Clk);
    #1;
    ALUOpFinal = 3'b111; InA = 8'h5A; InB = W'($urandom);
    @(negedge Clk);
    check("b2b and done", Done, 1);
    check("b2b and out", Out, 8'h30);
    @(posedge Clk);
    #1;
    Start = 1'b0;
    @(negedge Clk);
    check("b2b pass done", Done, 1);
    check("b2b pass out", Out, 8'h5A);
    check("b2b pass carry", Carry, 0);
    last_out = 8'h5A;

    // Reset in the middle of a long shift
    @(negedge Clk);
    Start = 1'b1; ALUOpFinal = 3'b011; InA = 8'h3B; InB = 8'd7;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst shift busy", Ready, 0);
    Reset = 1'b1;
    #1;
    check("rst mid out", Out, 0);
    check("rst mid zero", Zero, 0);
    check("rst mid carry", Carry, 0);
    check("rst mid done", Done, 0);
    check("rst mid ready", Ready, 1);
    @(negedge Clk);
    Reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      check("rst no done", Done, 0);
    end
    last_out = '0;
    do_op(0, 8'h12, 8'h34, "add after rst", 1'b0);

    for (int i = 0; i < 40; i++) begin
      do_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), "rand", 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
